// File: rtl/avl_vram_master.sv
// rtl/avl_vram_master.sv - Avalon-MM VRAM master with request FIFO, single reads/writes and a clear sweep
module avl_vram_master #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [9:0]  CLEAR_LAST = 10'd574,
    parameter logic [7:0]  CLEAR_DATA = 8'h80
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_read,
    input  logic [9:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       clear_start,
    output logic       clear_busy,
    output logic       M_READ,
    output logic       M_WRITE,
    output logic       M_CS,
    output logic       M_BYTE_EN,
    output logic [9:0] M_ADDR,
    output logic [7:0] M_WRITEDATA,
    input  logic [7:0] M_READDATA
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_READ_WAIT, S_CLEAR} state_t;

    state_t        state_q, state_d;
    logic [9:0]    clr_cnt_q, clr_cnt_d;
    logic          pop;

    logic [18:0]   fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, push;
    logic          head_read;
    logic [9:0]    head_addr;
    logic [7:0]    head_data;

    logic          m_read_d, m_write_d, m_cs_d, clear_busy_d, rsp_valid_d;
    logic [9:0]    m_addr_d;
    logic [7:0]    m_wdata_d;
    logic          m_read_q, m_write_q, m_cs_q, clear_busy_q, rsp_valid_q;
    logic [9:0]    m_addr_q;
    logic [7:0]    m_wdata_q, rsp_data_q;

    // Request FIFO: ready depends only on occupancy, so a full FIFO stalls even if a pop is due
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign req_ready = ~full;
    assign push      = req_valid & ~full;
    assign {head_read, head_addr, head_data} = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {req_read, req_addr, req_data};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = head_read ? S_READ : S_WRITE;
                end
            end
            S_WRITE:     state_d = S_IDLE;
            S_READ:      state_d = S_READ_WAIT;
            S_READ_WAIT: state_d = S_IDLE;
            S_CLEAR: begin
                if (clr_cnt_q == CLEAR_LAST) state_d = S_IDLE;
                else                         clr_cnt_d = clr_cnt_q + 10'd1;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered bus lines up with the state
    always_comb begin
        m_read_d     = (state_d == S_READ);
        m_write_d    = (state_d == S_WRITE) || (state_d == S_CLEAR);
        m_cs_d       = m_read_d | m_write_d;
        clear_busy_d = (state_d == S_CLEAR);
        rsp_valid_d  = (state_q == S_READ_WAIT);
        m_addr_d     = '0;
        m_wdata_d    = '0;
        case (state_d)
            S_WRITE: begin
                m_addr_d  = head_addr;
                m_wdata_d = head_data;
            end
            S_READ:  m_addr_d = head_addr;
            S_CLEAR: begin
                m_addr_d  = clr_cnt_d;
                m_wdata_d = CLEAR_DATA;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            m_cs_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            clear_busy_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            m_cs_q       <= m_cs_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            clear_busy_q <= clear_busy_d;
            rsp_valid_q  <= rsp_valid_d;
            if (state_q == S_READ_WAIT) rsp_data_q <= M_READDATA;
        end
    end

    assign M_READ      = m_read_q;
    assign M_WRITE     = m_write_q;
    assign M_CS        = m_cs_q;
    assign M_BYTE_EN   = m_cs_q;
    assign M_ADDR      = m_addr_q;
    assign M_WRITEDATA = m_wdata_q;
    assign clear_busy  = clear_busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
endmodule

// File: doc/avl_vram_master.md
AVL_VRAM_MASTER -- requirements
Module: avl_vram_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, request FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CLEAR_LAST, default 10'd574, last VRAM address written by a clear sweep (64 tiles + 510 status cells).
REQ-003 SHALL have parameter CLEAR_DATA, default 8'h80, byte written by a clear sweep (invisible bit set).
REQ-004 SHALL have port CLK  in  1  system clock, 50 MHz, shared with the VGA text slave.
REQ-005 SHALL have port RESET  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request FIFO can accept.
REQ-008 SHALL have port req_read  in  1  1 = read request, 0 = write request.
REQ-009 SHALL have port req_addr  in  10  VRAM byte address.
REQ-010 SHALL have port req_data  in  8  write byte; ignored for reads.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle pulse, read data valid.
REQ-012 SHALL have port rsp_data  out  8  read data, held until next rsp_valid.
REQ-013 SHALL have port clear_start  in  1  start clear sweep.
REQ-014 SHALL have port clear_busy  out  1  clear sweep in progress.
REQ-015 SHALL have ports M_READ, M_WRITE, M_CS, M_BYTE_EN  out  1 each  Avalon-MM master controls.
REQ-016 SHALL have port M_ADDR  out  10  Avalon-MM address.
REQ-017 SHALL have port M_WRITEDATA  out  8  Avalon-MM write data.
REQ-018 SHALL have port M_READDATA  in  8  Avalon-MM read data; slave has fixed read latency 1, no waitrequest.

Function
REQ-019 SHALL accept a request when req_valid & req_ready at a rising edge; {req_read, req_addr, req_data} pushed into FIFO.
REQ-020 SHALL drive req_ready = ~full (combinational from FIFO count, no same-cycle pop bypass); push while full is impossible by handshake.
REQ-021 SHALL support simultaneous push and pop in one cycle when not full; count unchanged.
REQ-022 SHALL implement FSM states IDLE, WRITE, READ, READ_WAIT, CLEAR.
REQ-023 IDLE: clear_start=1 -> CLEAR (priority over FIFO); else FIFO non-empty -> pop head, go WRITE or READ per req_read; else stay.
REQ-024 WRITE (1 cycle): M_CS=1, M_WRITE=1, M_BYTE_EN=1, M_ADDR/M_WRITEDATA from popped entry; -> IDLE.
REQ-025 READ (1 cycle): M_CS=1, M_READ=1, M_BYTE_EN=1, M_ADDR from entry; -> READ_WAIT.
REQ-026 READ_WAIT: capture M_READDATA into rsp_data, assert rsp_valid next cycle for exactly one cycle; -> IDLE.
REQ-027 Read latency: request pop to rsp_valid = 3 cycles (pop/READ, READ_WAIT, pulse).
REQ-028 CLEAR: one write per cycle, M_ADDR = counter from 0 to CLEAR_LAST, M_WRITEDATA = CLEAR_DATA; after writing CLEAR_LAST -> IDLE; CLEAR_LAST+1 write cycles total.
REQ-029 clear_busy SHALL be 1 in every CLEAR cycle, 0 otherwise.
REQ-030 clear_start outside IDLE SHALL be ignored (not queued).
REQ-031 FIFO SHALL continue accepting during CLEAR/READ/WRITE until full; order of FIFO requests preserved; requests wait until sweep completes.
REQ-032 M_READ and M_WRITE SHALL never be asserted together; M_CS=M_BYTE_EN=(M_READ|M_WRITE).
REQ-033 All bus outputs, rsp_valid, clear_busy SHALL be registered.

Reset
REQ-034 RESET=1 at an edge SHALL force state IDLE, FIFO empty, clear counter 0, all outputs 0 (req_ready=1 combinational after reset).
REQ-035 RESET mid-sweep or mid-read SHALL abort: no further bus cycles, no rsp_valid, queued requests discarded.

Verification
REQ-036 Write: push {0,10'd5,8'h1C} -> one cycle M_WRITE=1, M_ADDR=5, M_WRITEDATA=8'h1C, no rsp_valid.
REQ-037 Read: slave model returns 8'hA7 at addr 70; push read of 70 -> M_READ one cycle, rsp_valid pulse 3 cycles after pop, rsp_data=8'hA7.
REQ-038 Clear: clear_start in IDLE -> 575 consecutive writes addr 0..574 of 8'h80, clear_busy high exactly 575 cycles; second clear_start during sweep ignored.
REQ-039 Backpressure: during clear push 5 requests -> req_ready low after 4th, 5th held off; after sweep the 4 then 5th execute in order.
REQ-040 Reset mid-sweep at addr 100 with 2 queued -> no bus activity after reset, req_ready=1, clear_busy=0, rsp_valid never pulses.
